// File: rtl/ss_shift_sequencer.sv
// Serializes a word into an external shift register and reassembles the word
// returned on sr_q DEPTH cycles later; abortable, freezable via ena.
module ss_shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             dir,
    input  logic             abort,
    input  logic [WIDTH-1:0] data_in,
    input  logic             sr_q,
    output logic             sr_data,
    output logic             sr_enable,
    output logic             sr_leftright,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);

    localparam int CW = $clog2(WIDTH + DEPTH);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH + DEPTH - 1);
    localparam logic [CW-1:0] CNT_W    = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_D    = CW'(DEPTH);
    localparam logic [IW-1:0] IDX_MAX  = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             dir_q, dir_d;

    logic [CW-1:0]    rx_k;
    logic [IW-1:0]    tx_idx;
    logic [IW-1:0]    rx_idx;

    // Both bit pointers mirror for MSB-first so the loopback word comes back unchanged.
    always_comb begin
        rx_k   = cnt_q - CNT_D;
        tx_idx = dir_q ? (IDX_MAX - cnt_q[IW-1:0]) : cnt_q[IW-1:0];
        rx_idx = dir_q ? (IDX_MAX - rx_k[IW-1:0])  : rx_k[IW-1:0];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        data_out_d = data_out_q;
        dir_d      = dir_q;
        case (state_q)
            S_IDLE: begin
                if (ena && start) begin
                    tx_d    = data_in;
                    dir_d   = dir;
                    cnt_d   = '0;
                    rx_d    = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (ena) begin
                    if (cnt_q >= CNT_D) rx_d[rx_idx] = sr_q;
                    if (cnt_q == CNT_LAST) begin
                        // Final bit lands in the same edge, so publish rx_d, not rx_q.
                        data_out_d = rx_d;
                        state_d    = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            data_out_q <= '0;
            dir_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
        end
    end

    // Gated by rst_n so the shift-register controls are quiet while reset is held.
    assign sr_data      = rst_n && (state_q == S_SHIFT) && (cnt_q < CNT_W) && tx_q[tx_idx];
    assign sr_enable    = rst_n && (state_q == S_SHIFT) && ena;
    assign sr_leftright = rst_n && dir_q;
    assign busy         = rst_n && (state_q != S_IDLE);
    assign done         = rst_n && (state_q == S_DONE);
    assign data_out     = data_out_q;

endmodule
